// File: rtl/sync_seq_pkg.sv
// sync_seq_pkg: shared state encoding and default widths for the sync sequencer
package sync_seq_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_PER_W = 16;
endpackage

// File: rtl/sync_period_counter.sv
// sync_period_counter: loadable down-counter with terminal count, used for delay and half-period phases
module sync_period_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         tc
);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= value;
        else if (en && count != '0) count <= count - W'(1);
    end
    assign tc = count <= W'(1);
endmodule

// File: rtl/sync_sequencer.sv
// sync_sequencer: delayed, optionally bounded square-wave burst generator with stop and done signalling
module sync_sequencer
    import sync_seq_pkg::*;
#(
    parameter int FREQ_CLK = 50000000,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PER_W    = DEF_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_half_period,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [PER_W-1:0] cfg_periods,
    output logic             syncout,
    output logic             busy,
    output logic             edge_pulse,
    output logic             done
);
    state_t state;
    logic [CNT_W-1:0] half_lat, h_eff, cnt_value;
    logic [PER_W-1:0] per_lat, per_cnt;
    logic go, halt, cnt_load, tc, last;
    // Entering RUN loads a count of 1 so the first rise lands on the next edge
    always_comb begin
        h_eff     = half_lat == '0 ? CNT_W'(FREQ_CLK) : half_lat;
        go        = state == IDLE && start && !stop;
        halt      = state != IDLE && stop;
        cnt_load  = go || (!halt && state != IDLE && tc);
        cnt_value = state == IDLE ? (cfg_delay == '0 ? CNT_W'(1) : cfg_delay) :
                    state == DELAY ? CNT_W'(1) : h_eff;
        last      = state == RUN && tc && syncout && per_lat != '0 && per_cnt == per_lat - PER_W'(1);
    end
    sync_period_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (state != IDLE),
        .value (cnt_value),
        .tc    (tc)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            syncout    <= 1'b0;
            busy       <= 1'b0;
            edge_pulse <= 1'b0;
            done       <= 1'b0;
            half_lat   <= '0;
            per_lat    <= '0;
            per_cnt    <= '0;
        end else begin
            edge_pulse <= 1'b0;
            done       <= 1'b0;
            if (go) begin
                half_lat <= cfg_half_period;
                per_lat  <= cfg_periods;
                per_cnt  <= '0;
                state    <= cfg_delay == '0 ? RUN : DELAY;
                busy     <= 1'b1;
            end else if (halt) begin
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= 1'b1;
                syncout    <= 1'b0;
                edge_pulse <= syncout;
            end else if (state == DELAY && tc) begin
                state <= RUN;
            end else if (state == RUN && tc) begin
                syncout    <= !syncout;
                edge_pulse <= 1'b1;
                if (syncout && per_cnt != '1) per_cnt <= per_cnt + PER_W'(1);
                if (last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_sequencer.sv
// tb_sync_sequencer: directed checks of burst timing, delay, default period, stop, reset and contention
module tb_sync_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] cfg_half_period = '0;
    logic [31:0] cfg_delay = '0;
    logic [15:0] cfg_periods = '0;
    logic        syncout, busy, edge_pulse, done;
    int          n_checks = 0;
    int          n_errors = 0;

    sync_sequencer #(.FREQ_CLK(8), .CNT_W(32), .PER_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .cfg_half_period (cfg_half_period),
        .cfg_delay       (cfg_delay),
        .cfg_periods     (cfg_periods),
        .syncout         (syncout),
        .busy            (busy),
        .edge_pulse      (edge_pulse),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({syncout, edge_pulse, done, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_init got=%b exp=0000", {syncout, edge_pulse, done, busy});
        end
        reset = 1'b0;
        cfg_half_period = 4; cfg_delay = 0; cfg_periods = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({syncout, busy} !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_prerun got=%b exp=11", {syncout, busy});
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({syncout, edge_pulse, done, busy} !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=0000", i, {syncout, edge_pulse, done, busy});
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({syncout, edge_pulse, done, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_release got=%b exp=0000", {syncout, edge_pulse, done, busy});
        end
    endtask

    task automatic test_burst();
        logic [63:0] tog;
        logic        exp_s;
        logic [3:0]  exp;
        tog = '0;
        tog[1] = 1; tog[5] = 1; tog[9] = 1; tog[13] = 1; tog[17] = 1; tog[21] = 1;
        exp_s = 1'b0;
        cfg_half_period = 4; cfg_delay = 0; cfg_periods = 3;
        start = 1'b1;
        for (int j = 0; j <= 23; j++) begin
            tick();
            start = 1'b0;
            if (tog[j]) exp_s = ~exp_s;
            exp = {exp_s, tog[j], j == 21, j < 21};
            n_checks++;
            if ({syncout, edge_pulse, done, busy} !== exp) begin
                n_errors++;
                $display("FAIL burst j=%0d got=%b exp=%b", j, {syncout, edge_pulse, done, busy}, exp);
            end
        end
    endtask

    task automatic test_delay_min();
        logic [63:0] tog;
        logic        exp_s;
        logic [3:0]  exp;
        tog = '0;
        tog[6] = 1; tog[7] = 1; tog[8] = 1; tog[9] = 1;
        exp_s = 1'b0;
        cfg_half_period = 1; cfg_delay = 5; cfg_periods = 2;
        start = 1'b1;
        for (int j = 0; j <= 11; j++) begin
            tick();
            start = 1'b0;
            if (tog[j]) exp_s = ~exp_s;
            exp = {exp_s, tog[j], j == 9, j < 9};
            n_checks++;
            if ({syncout, edge_pulse, done, busy} !== exp) begin
                n_errors++;
                $display("FAIL delay_min j=%0d got=%b exp=%b", j, {syncout, edge_pulse, done, busy}, exp);
            end
        end
    endtask

    task automatic test_default_stop();
        logic [63:0] tog;
        logic        exp_s;
        logic [3:0]  exp;
        tog = '0;
        tog[1] = 1; tog[9] = 1; tog[17] = 1;
        exp_s = 1'b0;
        cfg_half_period = 0; cfg_delay = 0; cfg_periods = 0;
        start = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            tick();
            start = 1'b0;
            if (tog[j]) exp_s = ~exp_s;
            exp = {exp_s, tog[j], 1'b0, 1'b1};
            n_checks++;
            if ({syncout, edge_pulse, done, busy} !== exp) begin
                n_errors++;
                $display("FAIL default_run j=%0d got=%b exp=%b", j, {syncout, edge_pulse, done, busy}, exp);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({syncout, edge_pulse, done, busy} !== 4'b0110) begin
            n_errors++;
            $display("FAIL stop_high got=%b exp=0110", {syncout, edge_pulse, done, busy});
        end
        tick();
        n_checks++;
        if ({syncout, edge_pulse, done, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL stop_after got=%b exp=0000", {syncout, edge_pulse, done, busy});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({syncout, edge_pulse, done, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL stop_idle got=%b exp=0000", {syncout, edge_pulse, done, busy});
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_tab [0:6];
        exp_tab[0] = 4'b0001; exp_tab[1] = 4'b1101; exp_tab[2] = 4'b1001; exp_tab[3] = 4'b0110;
        exp_tab[4] = 4'b0001; exp_tab[5] = 4'b1101; exp_tab[6] = 4'b0110;
        cfg_half_period = 3; cfg_delay = 0; cfg_periods = 1;
        start = 1'b1; stop = 1'b1;
        tick();
        tick();
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if ({syncout, edge_pulse, done, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL start_stop_idle got=%b exp=0000", {syncout, edge_pulse, done, busy});
        end
        cfg_half_period = 2; cfg_delay = 0; cfg_periods = 1;
        start = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if ({syncout, edge_pulse, done, busy} !== exp_tab[j]) begin
                n_errors++;
                $display("FAIL back_to_back j=%0d got=%b exp=%b", j, {syncout, edge_pulse, done, busy}, exp_tab[j]);
            end
            if (j == 1) begin
                start = 1'b1;
                cfg_half_period = 7; cfg_delay = 3; cfg_periods = 5;
            end
            if (j == 3) begin
                start = 1'b1;
                cfg_half_period = 1; cfg_delay = 0; cfg_periods = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_delay_min();
        test_default_stop();
        test_contention();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
